// File: rtl/mod_counter.sv
// Modulo-MODULUS up/down counter with clear, clamped load and a terminal-count flag.
// Define MOD_COUNTER_SAT_EN to saturate at the bounds instead of wrapping.
module mod_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Dout,
  output logic             tc
);

  generate
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("mod_counter: WIDTH %0d outside 1..16", WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("mod_counter: MODULUS %0d outside 2..2^WIDTH", MODULUS);
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
  localparam logic [16:0]      MOD_U = 17'(MODULUS);

  logic             at_max, at_zero;
  logic [WIDTH-1:0] inc_val, dec_val, ld_val, cnt_d;

  assign at_max  = (Dout == MAX);
  assign at_zero = (Dout == '0);
  assign ld_val  = (17'(load_val) < MOD_U) ? load_val : MAX;

`ifdef MOD_COUNTER_SAT_EN
  assign inc_val = at_max  ? MAX : Dout + WIDTH'(1);
  assign dec_val = at_zero ? '0  : Dout - WIDTH'(1);
`else
  // With MODULUS == 2^WIDTH these collapse to natural binary overflow/underflow.
  assign inc_val = at_max  ? '0  : Dout + WIDTH'(1);
  assign dec_val = at_zero ? MAX : Dout - WIDTH'(1);
`endif

  always_comb begin
    cnt_d = Dout;
    if (clr)       cnt_d = '0;
    else if (load) cnt_d = ld_val;
    else if (en)   cnt_d = up_dn ? inc_val : dec_val;
  end

  always_ff @(posedge clk) begin
    if (!rst) Dout <= '0;
    else      Dout <= cnt_d;
  end

  // Flags the edge that will wrap, so a cascaded stage can use it as its enable.
  assign tc = en & ~clr & ~load & ((up_dn & at_max) | (~up_dn & at_zero));

endmodule

// File: tb/tb_mod_counter.sv
// Randomized self-checking bench for mod_counter against an arithmetic reference model.
module tb_mod_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, up_dn = 1'b0, clr = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic       casc_en = 1'b0;
  logic [2:0] dout8;
  logic [3:0] dout10, lo_q, hi_q;
  logic       tc8, tc10, tc_lo, tc_hi;

  int n_cmp = 0, n_err = 0;
  int m8 = 0, m10 = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val[2:0]), .Dout(dout8), .tc(tc8));

  mod_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .Dout(dout10), .tc(tc10));

  mod_counter #(.WIDTH(4), .MODULUS(10)) dut_lo (
    .clk(clk), .rst(rst), .en(casc_en), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .Dout(lo_q), .tc(tc_lo));

  mod_counter #(.WIDTH(4), .MODULUS(10)) dut_hi (
    .clk(clk), .rst(rst), .en(tc_lo), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .Dout(hi_q), .tc(tc_hi));

  function automatic int ref_next(int cur, int m, bit r, bit c, bit l, bit e, bit u, int lv);
    if (!r) return 0;
    if (c)  return 0;
    if (l)  return (lv < m) ? lv : m - 1;
    if (!e) return cur;
`ifdef MOD_COUNTER_SAT_EN
    if (u) return (cur == m - 1) ? cur : cur + 1;
    return (cur == 0) ? 0 : cur - 1;
`else
    if (u) return (cur + 1) % m;
    return (cur + m - 1) % m;
`endif
  endfunction

  function automatic bit ref_tc(int cur, int m, bit c, bit l, bit e, bit u);
    return e && !c && !l && ((u && cur == m - 1) || (!u && cur == 0));
  endfunction

  task automatic set(bit r, bit e, bit u, bit c, bit l, int lv);
    rst = r; en = e; up_dn = u; clr = c; load = l; load_val = 4'(lv);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    m8  = ref_next(m8,  8,  rst, clr, load, en, up_dn, int'(load_val) % 8);
    m10 = ref_next(m10, 10, rst, clr, load, en, up_dn, int'(load_val));
    #1;
  endtask

  task automatic test_reset();
    set(0, 1, 1, 1, 1, $urandom_range(0, 15));
    tick();
    n_cmp++; if (int'(dout8) !== 0) begin n_err++; $display("FAIL reset_dout8 got %0d want 0", dout8); end
    n_cmp++; if (int'(dout10) !== 0) begin n_err++; $display("FAIL reset_dout10 got %0d want 0", dout10); end
    // tc still follows the rule while held in reset
    set(0, 1, 0, 0, 0, 0);
    n_cmp++; if (tc8 !== ref_tc(m8, 8, clr, load, en, up_dn)) begin n_err++; $display("FAIL reset_tc8 got %0b want 1", tc8); end
    tick();
    n_cmp++; if (int'(dout8) !== 0) begin n_err++; $display("FAIL reset_hold got %0d want 0", dout8); end
  endtask

  task automatic test_count_up8();
    int exp;
    set(0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 9; i++) begin
      set(1, 1, 1, 0, 0, 0);
      n_cmp++; if (tc8 !== (int'(dout8) == 7)) begin n_err++; $display("FAIL up8_tc step %0d got %0b dout %0d", i, tc8, dout8); end
      tick();
      exp = (i + 1) % 8;
      n_cmp++; if (int'(dout8) !== exp) begin n_err++; $display("FAIL up8_dout step %0d got %0d want %0d", i, dout8, exp); end
    end
  endtask

  task automatic test_down10();
    set(1, 0, 0, 1, 0, 0); tick();
    set(1, 1, 0, 0, 0, 0);
    n_cmp++; if (tc10 !== 1'b1) begin n_err++; $display("FAIL down10_tc0 got %0b want 1", tc10); end
    tick();
    n_cmp++; if (int'(dout10) !== 9) begin n_err++; $display("FAIL down10_wrap got %0d want 9", dout10); end
    n_cmp++; if (tc10 !== 1'b0) begin n_err++; $display("FAIL down10_tc9 got %0b want 0", tc10); end
    tick();
    n_cmp++; if (int'(dout10) !== 8) begin n_err++; $display("FAIL down10_8 got %0d want 8", dout10); end
  endtask

  task automatic test_load_clamp();
    set(1, 0, 1, 0, 1, 13); tick();
    n_cmp++; if (int'(dout10) !== 9) begin n_err++; $display("FAIL load_clamp10 got %0d want 9", dout10); end
    n_cmp++; if (int'(dout8) !== 5) begin n_err++; $display("FAIL load_8 got %0d want 5", dout8); end
    set(1, 1, 1, 0, 1, 4);
    n_cmp++; if (tc10 !== 1'b0) begin n_err++; $display("FAIL load_tc got %0b want 0", tc10); end
    tick();
    n_cmp++; if (int'(dout10) !== 4) begin n_err++; $display("FAIL load_noinc got %0d want 4", dout10); end
  endtask

  task automatic test_priority();
    set(1, 0, 1, 0, 1, 5); tick();
    set(1, 1, 1, 1, 1, 3); tick();
    n_cmp++; if (int'(dout10) !== 0) begin n_err++; $display("FAIL clr_prio got %0d want 0", dout10); end
    set(1, 0, 1, 0, 1, 6); tick();
    n_cmp++; if (int'(dout10) !== 6) begin n_err++; $display("FAIL load6 got %0d want 6", dout10); end
    set(0, 1, 1, 1, 1, 3); tick();
    n_cmp++; if (int'(dout10) !== 0) begin n_err++; $display("FAIL rst_prio got %0d want 0", dout10); end
    // first enabled edge after release moves from 0
    set(1, 1, 1, 0, 0, 0); tick();
    n_cmp++; if (int'(dout10) !== 1) begin n_err++; $display("FAIL rst_release got %0d want 1", dout10); end
  endtask

  task automatic test_bounds8();
    int exp_up[3], exp_dn[3];
`ifdef MOD_COUNTER_SAT_EN
    exp_up = '{7, 7, 7}; exp_dn = '{0, 0, 0};
`else
    exp_up = '{7, 0, 1}; exp_dn = '{0, 7, 6};
`endif
    set(1, 0, 1, 0, 1, 6); tick();
    for (int i = 0; i < 3; i++) begin
      set(1, 1, 1, 0, 0, 0);
      n_cmp++; if (tc8 !== ref_tc(m8, 8, 0, 0, 1, 1)) begin n_err++; $display("FAIL bound_up_tc step %0d got %0b dout %0d", i, tc8, dout8); end
      tick();
      n_cmp++; if (int'(dout8) !== exp_up[i]) begin n_err++; $display("FAIL bound_up step %0d got %0d want %0d", i, dout8, exp_up[i]); end
    end
    set(1, 0, 0, 0, 1, 1); tick();
    for (int i = 0; i < 3; i++) begin
      set(1, 1, 0, 0, 0, 0); tick();
      n_cmp++; if (int'(dout8) !== exp_dn[i]) begin n_err++; $display("FAIL bound_dn step %0d got %0d want %0d", i, dout8, exp_dn[i]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set($urandom_range(0, 19) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15));
      n_cmp++; if (tc8 !== ref_tc(m8, 8, clr, load, en, up_dn)) begin n_err++; $display("FAIL rand_tc8 cyc %0d got %0b dout %0d", i, tc8, dout8); end
      n_cmp++; if (tc10 !== ref_tc(m10, 10, clr, load, en, up_dn)) begin n_err++; $display("FAIL rand_tc10 cyc %0d got %0b dout %0d", i, tc10, dout10); end
      tick();
      n_cmp++; if (int'(dout8) !== m8) begin n_err++; $display("FAIL rand_dout8 cyc %0d got %0d want %0d", i, dout8, m8); end
      n_cmp++; if (int'(dout10) !== m10) begin n_err++; $display("FAIL rand_dout10 cyc %0d got %0d want %0d", i, dout10, m10); end
    end
  endtask

  task automatic test_cascade();
`ifndef MOD_COUNTER_SAT_EN
    set(0, 0, 0, 0, 0, 0); tick();
    set(1, 0, 0, 0, 0, 0);
    casc_en = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      n_cmp++; if (tc_lo !== ((n - 1) % 10 == 9)) begin n_err++; $display("FAIL casc_tc edge %0d got %0b lo %0d", n, tc_lo, lo_q); end
      tick();
      n_cmp++; if (int'(lo_q) !== n % 10 || int'(hi_q) !== (n / 10) % 10) begin
        n_err++; $display("FAIL casc_pair edge %0d got %0d%0d want %0d%0d", n, hi_q, lo_q, (n / 10) % 10, n % 10);
      end
    end
    casc_en = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_count_up8();
    test_down10();
    test_load_clamp();
    test_priority();
    test_bounds8();
    test_random();
    test_cascade();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
